axi_txn_scheduler: RTL and testbench

//  Shares one myipAxi4-style AXI4 master engine (INIT_AXI_TXN / TXN_DONE / ERROR) among NUM_REQ requesters.

---
 rtl/axi_txn_scheduler_pkg.sv | 31 +++
 rtl/axi_txn_scheduler_rr_pick.sv | 45 ++++
 rtl/axi_txn_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_axi_txn_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_txn_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// axi_txn_scheduler_pkg
// Shared definitions for the AXI transaction scheduler:
//   - sched_state_t : FSM state encoding (3 bits)
//   - idx_width     : width of a requester index for a given requester count
//   - cnt_width     : width of a counter that must be able to hold 'limit'
// -----------------------------------------------------------------------------
package axi_txn_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_GUARD  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } sched_state_t;

  // A single-requester index still needs one bit so ports never collapse to zero width.
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/axi_txn_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// axi_txn_rr_pick
// Combinational rotate-priority encoder. Searches req starting at (ptr+1)
// mod NUM_REQ and wrapping, so the requester served last has lowest priority.
// Ports:
//   req        in  NUM_REQ  request vector
//   ptr        in  IDX_W    index of the most recently served requester
//   win_onehot out NUM_REQ  one-hot winner (all zero when req is zero)
//   win_idx    out IDX_W    index of the winner (zero when req is zero)
// -----------------------------------------------------------------------------
module axi_txn_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx
);

  logic               found_s;
  int                 cand_s;
  logic [NUM_REQ-1:0] req_sh_s;

  // Walk the candidates in rotation order and keep the first active one.
  always_comb begin
    win_onehot = {NUM_REQ{1'b0}};
    win_idx    = {IDX_W{1'b0}};
    found_s    = 1'b0;
    cand_s     = 0;
    req_sh_s   = req;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s   = (int'(ptr) + k) % NUM_REQ;
      req_sh_s = req >> cand_s;
      if (!found_s && req_sh_s[0]) begin
        found_s    = 1'b1;
        win_idx    = IDX_W'(cand_s);
        win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/axi_txn_scheduler.sv
// -----------------------------------------------------------------------------
// axi_txn_scheduler
// Shares one AXI4 master engine (INIT_AXI_TXN / TXN_DONE / ERROR) among
// NUM_REQ requesters. Round-robin grants one requester, loads its base address
// onto the engine, pulses init for one cycle, ignores TXN_DONE for GUARD_CYC
// cycles (engine may still show the previous done), then waits for done under
// a watchdog and returns a one-cycle done/err pulse to the granted requester.
// Ports:
//   ACLK, ARESET    clock / synchronous active-high reset
//   req, req_addr   level requests and per-requester base addresses
//   grant           one-hot, LAUNCH through REPORT
//   done, err       one-cycle completion pulse and its error flag
//   busy            high outside IDLE
//   timeout_seen    sticky watchdog-expiry flag
//   m_init_txn      one-cycle engine start pulse
//   m_base_addr     captured base address for the engine
//   m_txn_done      engine done level
//   m_error         engine error level, sampled with m_txn_done
// GUARD_CYC must be between 1 and TIMEOUT_CYC (guard and watchdog share a counter).
// -----------------------------------------------------------------------------
module axi_txn_scheduler
  import axi_txn_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int GUARD_CYC   = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      busy,
  output logic                      timeout_seen,
  output logic                      m_init_txn,
  output logic [ADDR_W-1:0]         m_base_addr,
  input  logic                      m_txn_done,
  input  logic                      m_error
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] PTR_RST    = IDX_W'(NUM_REQ - 1);

  sched_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_d_s;
  logic [IDX_W-1:0]    ptr_r, ptr_d_s;
  logic [IDX_W-1:0]    gidx_r, gidx_d_s;
  logic [NUM_REQ-1:0]  grant_r, grant_d_s;
  logic [NUM_REQ-1:0]  done_r, done_d_s;
  logic [NUM_REQ-1:0]  err_r, err_d_s;
  logic                busy_r, busy_d_s;
  logic                init_r, init_d_s;
  logic                to_r, to_d_s;
  logic [ADDR_W-1:0]   addr_r, addr_d_s;
  logic [NUM_REQ-1:0]  win_oh_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic [ADDR_W-1:0]   addr_arr_s [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr_split
    assign addr_arr_s[gi] = req_addr[gi*ADDR_W +: ADDR_W];
  end

  axi_txn_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .ptr        (ptr_r),
    .win_onehot (win_oh_s),
    .win_idx    (win_idx_s)
  );

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic. In WAIT a done on the expiry cycle still counts as done.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_nxt_s = ST_LAUNCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_nxt_s = ST_GUARD;
      ST_GUARD: begin
        if (cnt_r == GUARD_LAST) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_GUARD;
        end
      end
      ST_WAIT: begin
        if (m_txn_done || (cnt_r == WD_LAST)) begin
          state_nxt_s = ST_REPORT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_REPORT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values; every output is registered one step later so
  // the pulses land in the state they belong to (init in LAUNCH, done in REPORT).
  always_comb begin
    cnt_d_s   = cnt_r;
    ptr_d_s   = ptr_r;
    gidx_d_s  = gidx_r;
    grant_d_s = grant_r;
    done_d_s  = {NUM_REQ{1'b0}};
    err_d_s   = {NUM_REQ{1'b0}};
    init_d_s  = 1'b0;
    to_d_s    = to_r;
    addr_d_s  = addr_r;
    busy_d_s  = (state_nxt_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          grant_d_s = win_oh_s;
          gidx_d_s  = win_idx_s;
          addr_d_s  = addr_arr_s[win_idx_s];
          init_d_s  = 1'b1;
          cnt_d_s   = {CNT_W{1'b0}};
        end else begin
          grant_d_s = {NUM_REQ{1'b0}};
        end
      end
      ST_LAUNCH: cnt_d_s = {CNT_W{1'b0}};
      ST_GUARD: begin
        // Counter is reloaded here so the watchdog starts from zero in WAIT.
        if (cnt_r == GUARD_LAST) begin
          cnt_d_s = {CNT_W{1'b0}};
        end else begin
          cnt_d_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (m_txn_done) begin
          done_d_s = grant_r;
          err_d_s  = m_error ? grant_r : {NUM_REQ{1'b0}};
        end else if (cnt_r == WD_LAST) begin
          done_d_s = grant_r;
          err_d_s  = grant_r;
          to_d_s   = 1'b1;
        end else begin
          cnt_d_s = cnt_r + CNT_W'(1);
        end
      end
      ST_REPORT: begin
        grant_d_s = {NUM_REQ{1'b0}};
        ptr_d_s   = gidx_r;
        cnt_d_s   = {CNT_W{1'b0}};
      end
      default: begin
        grant_d_s = {NUM_REQ{1'b0}};
        cnt_d_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_r   <= {CNT_W{1'b0}};
      ptr_r   <= PTR_RST;
      gidx_r  <= {IDX_W{1'b0}};
      grant_r <= {NUM_REQ{1'b0}};
      done_r  <= {NUM_REQ{1'b0}};
      err_r   <= {NUM_REQ{1'b0}};
      busy_r  <= 1'b0;
      init_r  <= 1'b0;
      to_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
    end else begin
      cnt_r   <= cnt_d_s;
      ptr_r   <= ptr_d_s;
      gidx_r  <= gidx_d_s;
      grant_r <= grant_d_s;
      done_r  <= done_d_s;
      err_r   <= err_d_s;
      busy_r  <= busy_d_s;
      init_r  <= init_d_s;
      to_r    <= to_d_s;
      addr_r  <= addr_d_s;
    end
  end

  assign grant        = grant_r;
  assign done         = done_r;
  assign err          = err_r;
  assign busy         = busy_r;
  assign timeout_seen = to_r;
  assign m_init_txn   = init_r;
  assign m_base_addr  = addr_r;

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_axi_txn_scheduler
// Drives axi_txn_scheduler with directed scenarios and random traffic, emulates
// the AXI engine, and compares every output on every cycle with a
// transaction-timeline model (launch cycle, guard window, wait window, report).
// -----------------------------------------------------------------------------
module tb_axi_txn_scheduler;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int G  = 2;
  localparam int T  = 64;

  logic            tb_ACLK = 1'b0;
  logic            areset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    grant, done, err;
  logic            busy, timeout_seen, m_init_txn;
  logic [AW-1:0]   m_base_addr;
  logic            m_txn_done, m_error;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_txn_scheduler #(
    .NUM_REQ(N), .ADDR_W(AW), .GUARD_CYC(G), .TIMEOUT_CYC(T)
  ) dut (
    .ACLK(tb_ACLK), .ARESET(areset), .req(req), .req_addr(req_addr),
    .grant(grant), .done(done), .err(err), .busy(busy),
    .timeout_seen(timeout_seen), .m_init_txn(m_init_txn),
    .m_base_addr(m_base_addr), .m_txn_done(m_txn_done), .m_error(m_error)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model: one transaction at a time, described by its launch and report cycles
  bit            mb = 1'b0;
  int            mg = 0, mptr = N-1, mL = 0, mend = -1;
  bit            merr = 1'b0, mto = 1'b0;
  logic [AW-1:0] maddr = '0;

  // engine emulation
  int eng_launch = -1, eng_delay = -1;
  bit eng_err = 1'b0, eng_stale = 1'b0, eng_rand = 1'b0, addr_churn = 1'b0;

  // observations
  int            init_cyc = 0, done_cyc = 0;
  logic [N-1:0]  done_obs = '0, err_obs = '0;
  logic          to_obs = 1'b0;
  logic [AW-1:0] init_addr = '0;
  bit            prev_init = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input logic rs, input logic [N-1:0] rq,
                            input logic [N*AW-1:0] ra, input logic ds, input logic es);
    int k;
    bit found;
    if (rs) begin
      mb = 1'b0; mptr = N-1; maddr = '0; mto = 1'b0; mend = -1;
    end else if (!mb) begin
      if (rq != '0) begin
        found = 1'b0;
        for (int s = 1; s <= N; s++) begin
          if (!found && rq[(mptr + s) % N]) begin
            found = 1'b1;
            mg = (mptr + s) % N;
          end
        end
        mb = 1'b1; mL = cyc; mend = -1; maddr = ra[mg*AW +: AW];
      end
    end else if (mend >= 0) begin
      mb = 1'b0; mptr = mg;
    end else begin
      k = (cyc - 1) - mL;
      if (k >= G + 1) begin
        if (ds) begin
          mend = cyc; merr = es;
        end else if (k - G == T) begin
          mend = cyc; merr = 1'b1; mto = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    logic rs, ds, es;
    logic [N-1:0] rq, eg, ed, ee;
    logic [N*AW-1:0] ra;
    int k, r;
    bit d;
    rs = areset; rq = req; ra = req_addr; ds = m_txn_done; es = m_error;
    @(posedge tb_ACLK);
    cyc++;
    model_edge(rs, rq, ra, ds, es);
    #1;
    eg = '0; ed = '0; ee = '0;
    if (mb) eg[mg] = 1'b1;
    if (mb && cyc == mend) begin
      ed[mg] = 1'b1; ee[mg] = merr;
    end
    chk("grant", 64'(grant), 64'(eg));
    chk("done", 64'(done), 64'(ed));
    chk("err", 64'(err), 64'(ee));
    chk("busy", 64'(busy), 64'(mb));
    chk("timeout_seen", 64'(timeout_seen), 64'(mto));
    chk("m_init_txn", 64'(m_init_txn), 64'(mb && cyc == mL));
    chk("m_base_addr", 64'(m_base_addr), 64'(maddr));
    if (m_init_txn) chk("init_back_to_back", 64'(prev_init), 64'd0);
    prev_init = m_init_txn;
    if (m_init_txn) begin
      init_cyc = cyc; eng_launch = cyc; init_addr = m_base_addr;
      if (eng_rand) begin
        r = $urandom_range(0, 9);
        if (r == 0) eng_delay = -1;
        else if (r == 1) eng_delay = $urandom_range(62, 70);
        else eng_delay = $urandom_range(1, 30);
        eng_err = 1'($urandom_range(0, 1));
      end
    end
    if (done != '0) begin
      done_cyc = cyc; done_obs = done; err_obs = err; to_obs = timeout_seen;
    end
    // engine levels for the coming cycle
    if (eng_launch < 0) begin
      d = 1'b0;
    end else begin
      k = cyc - eng_launch;
      if (eng_stale && k <= 1) d = 1'b1;
      else d = (eng_delay >= 0) && (k >= eng_delay);
    end
    m_txn_done = d;
    m_error = d ? eng_err : 1'($urandom_range(0, 1));
    if (addr_churn) begin
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = $urandom;
    end
  endtask

  task automatic run_txn(input int budget);
    int n;
    bit got;
    n = 0; got = 1'b0; done_obs = '0; err_obs = '0;
    while (!got && n < budget) begin
      step();
      n++;
      if (done != '0) got = 1'b1;
    end
    chk("txn_wait_budget", 64'(got), 64'd1);
  endtask

  task automatic wait_init(input int budget);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (!got && n < budget) begin
      step();
      n++;
      if (m_init_txn) got = 1'b1;
    end
    chk("init_wait_budget", 64'(got), 64'd1);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step();
    areset = 1'b0;
  endtask

  int exp_rot[5] = '{0, 1, 2, 3, 0};

  initial begin
    areset = 1'b1; req = '0; req_addr = '0; m_txn_done = 1'b0; m_error = 1'b0;
    repeat (3) step();
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_addr", 64'(m_base_addr), 64'd0);
    areset = 1'b0;

    // single transaction, engine done 20 cycles after init
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = $urandom;
    req_addr[31:0] = 32'h4000_0000;
    req = 4'b0001; eng_delay = 20; eng_err = 1'b0;
    run_txn(200);
    chk("t1_done", 64'(done_obs), 64'h1);
    chk("t1_err", 64'(err_obs), 64'h0);
    chk("t1_latency", 64'(done_cyc - init_cyc), 64'd21);
    chk("t1_addr", 64'(init_addr), 64'h4000_0000);
    req = '0;
    repeat (3) step();

    // rotation with all four requesting, addresses changing every cycle
    do_reset();
    req = 4'b1111; addr_churn = 1'b1;
    for (int t = 0; t < 5; t++) begin
      eng_delay = $urandom_range(3, 15);
      run_txn(200);
      chk("t2_rotation", 64'(done_obs), 64'(4'b0001 << exp_rot[t]));
      chk("t2_err", 64'(err_obs), 64'h0);
    end
    req = '0; addr_churn = 1'b0;
    repeat (3) step();

    // stale done held across launch, dropped in guard, raised again 10 cycles later
    req = 4'b0100; eng_stale = 1'b1; eng_delay = 12; eng_err = 1'b0;
    run_txn(200);
    chk("t3_done", 64'(done_obs), 64'h4);
    chk("t3_latency", 64'(done_cyc - init_cyc), 64'd13);
    eng_stale = 1'b0; req = '0;
    repeat (3) step();

    // engine error, then watchdog timeout
    req = 4'b1000; eng_delay = 5; eng_err = 1'b1;
    run_txn(200);
    chk("t4_err_done", 64'(done_obs), 64'h8);
    chk("t4_err_flag", 64'(err_obs), 64'h8);
    chk("t4_no_timeout", 64'(to_obs), 64'd0);
    req = 4'b0010; eng_delay = -1; eng_err = 1'b0;
    run_txn(200);
    chk("t4_to_done", 64'(done_obs), 64'h2);
    chk("t4_to_err", 64'(err_obs), 64'h2);
    chk("t4_to_latency", 64'(done_cyc - init_cyc), 64'd67);
    chk("t4_to_seen", 64'(to_obs), 64'd1);
    req = '0;
    repeat (5) step();
    chk("t4_to_sticky", 64'(timeout_seen), 64'd1);

    // done arriving on the expiry cycle wins
    do_reset();
    req = 4'b0001; eng_delay = 66; eng_err = 1'b0;
    run_txn(200);
    chk("t5_done", 64'(done_obs), 64'h1);
    chk("t5_err", 64'(err_obs), 64'h0);
    chk("t5_latency", 64'(done_cyc - init_cyc), 64'd67);
    chk("t5_no_timeout", 64'(to_obs), 64'd0);
    req = '0;
    repeat (3) step();

    // reset in the middle of WAIT
    req = 4'b0010; eng_delay = -1;
    wait_init(50);
    repeat (10) step();
    areset = 1'b1; req = 4'b0110;
    step();
    areset = 1'b0;
    chk("t6_grant", 64'(grant), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_init", 64'(m_init_txn), 64'd0);
    chk("t6_addr", 64'(m_base_addr), 64'd0);
    eng_delay = 4;
    wait_init(50);
    chk("t6_regrant", 64'(grant), 64'h2);
    run_txn(200);
    chk("t6_done", 64'(done_obs), 64'h2);
    req = '0;
    repeat (3) step();

    // random traffic
    eng_rand = 1'b1; addr_churn = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      areset = ($urandom_range(0, 999) == 0);
      step();
    end
    areset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
